pwm_multi: RTL and testbench

Multi-channel PWM generator on the CPLD's 8-bit CSR bus. One shared period counter drives CHANNELS compare outputs. The block adds a programmable period, a prescaler, per-channel polarity, a centre-aligned mode, and shadowed period/duty updates that apply only at period boundaries. It sits beside the other CSR peripherals and drives fan and backlight pins.

---
 rtl/pwm_multi_pkg.sv | 23 ++
 rtl/pwm_multi_chan.sv | 27 ++
 rtl/pwm_multi.sv | 126 ++++++++++++
 tb/tb_pwm_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_multi_pkg;

  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;

  localparam logic [4:0] OFF_CTRL   = 5'd0;
  localparam logic [4:0] OFF_PERIOD = 5'd1;
  localparam logic [4:0] OFF_DUTY0  = 5'd2;

  // CTRL bits 5:4 are reserved and always read back as zero
  localparam logic [7:0] CTRL_MASK = 8'hCF;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_e;

  function automatic logic [4:0] off_pol(input int channels);
    return 5'(2 + channels);
  endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// One PWM channel: duty shadow, compare against the shared counter, polarity, output flop.
module pwm_multi_chan
  import pwm_multi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] duty,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic             pol,
  output logic             pwm_out
);

  logic [CNT_W-1:0] act_duty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_duty <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (load) act_duty <= duty;
      pwm_out <= (en && (cnt < act_duty)) ^ pol;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM on the 8-bit CSR bus: shared prescaled counter (edge or centre
// aligned) with period/duty shadows that reload only at period boundaries.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int         CHANNELS  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic                pwm_ce,
  output logic                pwm_en,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [4:0] OFF_POL = off_pol(CHANNELS);

  logic [7:0]                 ctrl;
  logic [CNT_W-1:0]           period;
  logic [CHANNELS-1:0][7:0]   duty;
  logic [CHANNELS-1:0]        pol;

  logic [4:0]                 off;
  logic                       en;
  mode_e                      mode;
  logic [PRESC_W-1:0]         presc, presc_cnt;
  logic [CNT_W-1:0]           cnt, act_period;
  logic                       dir_down;
  logic                       wr_ctrl, restart, tick, bound, load;

  assign off     = csr_a - BASE_ADDR;
  assign en      = ctrl[7];
  assign mode    = mode_e'(ctrl[6]);
  assign presc   = ctrl[PRESC_W-1:0];
  assign pwm_en  = en;

  assign wr_ctrl = csr_we && (off == OFF_CTRL);
  assign restart = wr_ctrl && ((csr_di[6] != ctrl[6]) || (csr_di[7] && !en));
  assign tick    = pwm_ce && (presc_cnt == presc);

  // Period boundary: wrap in edge mode, down->up turnaround at 0 in centre mode
  always_comb begin
    bound = 1'b0;
    if (mode == MODE_EDGE) bound = (cnt >= act_period);
    else                   bound = (act_period == '0) || (dir_down && cnt == '0);
  end

  assign load = !en || restart || (tick && bound);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl   <= '0;
      period <= '0;
      duty   <= '0;
      pol    <= '0;
    end else if (csr_we) begin
      if (off == OFF_CTRL)   ctrl   <= csr_di & CTRL_MASK;
      if (off == OFF_PERIOD) period <= csr_di;
      if (off == OFF_POL)    pol    <= csr_di[CHANNELS-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (off == OFF_DUTY0 + 5'(i)) duty[i] <= csr_di;
    end
  end

  always_comb begin
    csr_do = '0;
    if (off == OFF_CTRL)        csr_do = ctrl;
    else if (off == OFF_PERIOD) csr_do = period;
    else if (off == OFF_POL)    csr_do[CHANNELS-1:0] = pol;
    for (int i = 0; i < CHANNELS; i++)
      if (off == OFF_DUTY0 + 5'(i)) csr_do = duty[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      presc_cnt  <= '0;
      dir_down   <= 1'b0;
      act_period <= '0;
    end else if (!en || restart) begin
      cnt        <= '0;
      presc_cnt  <= '0;
      dir_down   <= 1'b0;
      act_period <= period;
    end else begin
      if (pwm_ce) presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        if (bound) begin
          // Centre mode leaves 0 upwards with the freshly loaded period
          act_period <= period;
          dir_down   <= 1'b0;
          cnt        <= (mode == MODE_CENTRE && period != '0) ? CNT_W'(1) : '0;
        end else if (mode == MODE_EDGE) begin
          cnt <= cnt + 1'b1;
        end else if (!dir_down) begin
          if (cnt >= act_period) begin
            dir_down <= 1'b1;
            cnt      <= cnt - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_multi_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty    (duty[g]),
      .load    (load),
      .en      (en),
      .cnt     (cnt),
      .pol     (pol[g]),
      .pwm_out (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected values queued with stimulus, popped on observation.
module tb_pwm_multi;

  localparam int CH = 2;
  localparam logic [4:0] A_CTRL = 5'd0, A_PER = 5'd1, A_D0 = 5'd2, A_D1 = 5'd3,
                         A_POL = 5'd4, A_NONE = 5'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    csr_a = '0;
  logic [7:0]    csr_di = '0;
  logic          csr_we = 1'b0;
  logic [7:0]    csr_do;
  logic          pwm_ce = 1'b1;
  logic          pwm_en;
  logic [CH-1:0] pwm_out;

  int total = 0;
  int bad   = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  pwm_multi #(.BASE_ADDR(5'h0), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .csr_a   (csr_a),
    .csr_di  (csr_di),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .pwm_ce  (pwm_ce),
    .pwm_en  (pwm_en),
    .pwm_out (pwm_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input int got);
    int e;
    e = (sb_q.size() == 0) ? -1 : sb_q.pop_front();
    chk(tag, got, e);
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input int e);
    sb_q.push_back(e);
    csr_a = a;
    #1;
    sb_cmp(tag, int'(csr_do));
  endtask

  task automatic wait_rise(input int ch);
    logic prev;
    prev = pwm_out[ch];
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!prev && pwm_out[ch]) return;
      prev = pwm_out[ch];
    end
    chk("rise_timeout", 0, 1);
  endtask

  // Counts negedge samples at level lvl, starting with the current one
  task automatic count_run(input int ch, input logic lvl, input int lim, output int len);
    len = 0;
    while (pwm_out[ch] == lvl && len < lim) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input string tag, input int ch, input logic lvl, input int e);
    int len;
    sb_q.push_back(e);
    count_run(ch, lvl, 300, len);
    sb_cmp(tag, len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, hi;
    repeat (3) @(negedge clk);
    rd_chk("por_ctrl", A_CTRL, 0);
    sb_q.push_back(0); sb_cmp("por_out", int'(pwm_out));
    rst_n = 1'b1;
    @(negedge clk);

    // Edge mode
    wr(A_PER, 8'd9);
    wr(A_D0, 8'd3);
    wr(A_D1, 8'd0);
    wr(A_CTRL, 8'h80);
    rd_chk("rd_ctrl", A_CTRL, 8'h80);
    rd_chk("rd_per", A_PER, 9);
    sb_q.push_back(1); sb_cmp("pwm_en", int'(pwm_en));
    wait_rise(0);
    run_chk("edge_hi", 0, 1'b1, 3);
    run_chk("edge_lo", 0, 1'b0, 7);
    run_chk("edge_hi2", 0, 1'b1, 3);
    run_chk("edge_lo2", 0, 1'b0, 7);
    sb_q.push_back(25);
    count_run(1, 1'b0, 25, len);
    sb_cmp("out1_low", len);

    // Shadowing: DUTY0=7 written at the edge where cnt=5
    wait_rise(0);
    run_chk("shd_hi_old", 0, 1'b1, 3);
    @(negedge clk);
    wr(A_D0, 8'd7);
    rd_chk("rd_d0", A_D0, 7);
    run_chk("shd_lo_rest", 0, 1'b0, 5);
    run_chk("shd_hi_new", 0, 1'b1, 7);
    run_chk("shd_lo_new", 0, 1'b0, 3);

    // Centre mode
    wr(A_PER, 8'd4);
    wr(A_D0, 8'd2);
    wr(A_CTRL, 8'hC0);
    wait_rise(0);
    run_chk("ctr_hi", 0, 1'b1, 3);
    run_chk("ctr_lo", 0, 1'b0, 5);
    run_chk("ctr_hi2", 0, 1'b1, 3);
    run_chk("ctr_lo2", 0, 1'b0, 5);

    // Boundaries
    wr(A_PER, 8'd9);
    wr(A_D0, 8'd10);
    wr(A_CTRL, 8'h80);
    repeat (3) @(negedge clk);
    sb_q.push_back(40);
    count_run(0, 1'b1, 40, len);
    sb_cmp("duty_gt_per", len);
    wr(A_CTRL, 8'h00);
    wr(A_POL, 8'h02);
    repeat (2) @(negedge clk);
    sb_q.push_back(2); sb_cmp("pol_dis", int'(pwm_out));
    sb_q.push_back(0); sb_cmp("pwm_en_off", int'(pwm_en));
    rd_chk("rd_pol", A_POL, 2);
    rd_chk("rd_unmapped", A_NONE, 0);
    rd_chk("rd_hi_addr", 5'd31, 0);

    // Prescaler
    wr(A_POL, 8'h00);
    wr(A_D0, 8'd3);
    wr(A_CTRL, 8'h83);
    rd_chk("rd_presc", A_CTRL, 8'h83);
    wait_rise(0);
    run_chk("psc_hi", 0, 1'b1, 12);
    run_chk("psc_lo", 0, 1'b0, 28);
    wait_rise(0);
    pwm_ce = 1'b0;
    hi = 0;
    repeat (5) begin
      if (pwm_out[0]) hi++;
      @(negedge clk);
    end
    pwm_ce = 1'b1;
    sb_q.push_back(5); sb_cmp("stall_hi", hi);
    sb_q.push_back(17);
    count_run(0, 1'b1, 300, len);
    sb_cmp("stall_stretch", hi + len);
    run_chk("stall_lo", 0, 1'b0, 28);

    // Reset mid-operation with inverted polarity
    wr(A_POL, 8'h03);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb_q.push_back(0); sb_cmp("rst_out", int'(pwm_out));
    sb_q.push_back(0); sb_cmp("rst_en", int'(pwm_en));
    rd_chk("rst_ctrl", A_CTRL, 0);
    rd_chk("rst_per", A_PER, 0);
    rd_chk("rst_d0", A_D0, 0);
    rd_chk("rst_d1", A_D1, 0);
    rd_chk("rst_pol", A_POL, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb_q.push_back(0); sb_cmp("post_rst_out", int'(pwm_out));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
